// File: rtl/fetch_unit.sv
// Instruction store plus sequential fetch stage: programs are loaded while idle, then
// fetched from address 0 until a halt word (icode 0) or the end of memory.
module fetch_unit #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic [31:0]       wdata,
  input  logic              working,
  input  logic              stall,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [15:0]       valC,
  output logic [ADDR_W-1:0] ipc,
  output logic              valid,
  output logic              done
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   pc_q;
  logic [31:0]       ir_q;
  logic [ADDR_W-1:0] ipc_q;
  logic              valid_q;
  logic              done_q;
  logic [31:0]       mem_q [Depth];

  logic [31:0] fetch_word;
  logic        at_end;

  // pc is one bit wider than the address so pc == Depth flags end of memory without wrapping.
  assign fetch_word = mem_q[pc_q[ADDR_W-1:0]];
  assign at_end     = (pc_q == (ADDR_W + 1)'(Depth));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (state_q == StIdle && wr && !working) begin
        mem_q[addr] <= wdata;
      end

      unique case (state_q)
        StIdle: begin
          if (working) begin
            state_q <= StRun;
            pc_q    <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        StRun: begin
          if (!working) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
          end else if (stall && valid_q) begin
            // Downstream hold: IR, ipc, pc and valid all keep their values.
          end else if (at_end || fetch_word[31:28] == 4'd0) begin
            state_q <= StHalt;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ir_q    <= fetch_word;
            ipc_q   <= pc_q[ADDR_W-1:0];
            valid_q <= 1'b1;
            pc_q    <= pc_q + 1'b1;
          end
        end
        StHalt: begin
          if (!working) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign icode = ir_q[31:28];
  assign ifun  = ir_q[27:24];
  assign rA    = ir_q[23:20];
  assign rB    = ir_q[19:16];
  assign valC  = ir_q[15:0];
  assign ipc   = ipc_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: load, run, stall, ignored writes, full memory,
// run abort and asynchronous reset.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  addr = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        working = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [15:0] valC;
  logic [4:0]  ipc;
  logic        valid, done;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.ADDR_W(5)) dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .wr     (wr),
    .wdata  (wdata),
    .working(working),
    .stall  (stall),
    .icode  (icode),
    .ifun   (ifun),
    .rA     (rA),
    .rB     (rB),
    .valC   (valC),
    .ipc    (ipc),
    .valid  (valid),
    .done   (done)
  );

  always #5 clock = ~clock;

  // One active edge, then sample and drive on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load_word(input logic [4:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    step();
    wr    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({valid, done, ipc, icode, valC} !== {1'b0, 1'b0, 5'd0, 4'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b done=%b ipc=%0d icode=%h valC=%h want all 0",
               valid, done, ipc, icode, valC);
    end
  endtask

  task automatic test_basic_run();
    logic [3:0]  exp_icode [3];
    logic [3:0]  exp_rb [3];
    logic [15:0] exp_valc [3];
    exp_icode = '{4'h1, 4'h1, 4'h2};
    exp_rb    = '{4'h0, 4'h1, 4'h1};
    exp_valc  = '{16'h0080, 16'h0081, 16'h0000};
    load_word(5'd0, 32'h10F00080);
    load_word(5'd1, 32'h10F10081);
    load_word(5'd2, 32'h20010000);
    working = 1'b1;
    step();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_entry_latency: valid=%b want 0", valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({valid, icode, rB, valC, ipc} !== {1'b1, exp_icode[i], exp_rb[i], exp_valc[i], 5'(i)}) begin
        miscompares++;
        $display("FAIL basic_issue%0d: got v=%b icode=%h rB=%h valC=%h ipc=%0d want v=1 %h %h %h %0d",
                 i, valid, icode, rB, valC, ipc, exp_icode[i], exp_rb[i], exp_valc[i], i);
      end
    end
    step();
    vectors++;
    if ({valid, done, ipc} !== {1'b0, 1'b1, 5'd2}) begin
      miscompares++;
      $display("FAIL basic_halt: got valid=%b done=%b ipc=%0d want 0 1 2", valid, done, ipc);
    end
    step();
    vectors++;
    if ({valid, done} !== 2'b01) begin
      miscompares++;
      $display("FAIL basic_halt_stays: got valid=%b done=%b want 0 1", valid, done);
    end
    working = 1'b0;
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_clear: done=%b want 0", done);
    end
  endtask

  task automatic test_stall();
    int issues;
    issues = 0;
    working = 1'b1;
    step();
    step();
    if (valid === 1'b1) issues++;
    step();
    if (valid === 1'b1) issues++;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({valid, ipc, icode, rB, valC} !== {1'b1, 5'd1, 4'h1, 4'h1, 16'h0081}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got v=%b ipc=%0d icode=%h rB=%h valC=%h want 1 1 1 1 0081",
                 i, valid, ipc, icode, rB, valC);
      end
    end
    stall = 1'b0;
    step();
    if (valid === 1'b1) issues++;
    vectors++;
    if ({valid, ipc, icode} !== {1'b1, 5'd2, 4'h2}) begin
      miscompares++;
      $display("FAIL stall_resume: got v=%b ipc=%0d icode=%h want 1 2 2", valid, ipc, icode);
    end
    step();
    vectors++;
    if ({valid, done, issues} !== {1'b0, 1'b1, 32'd3}) begin
      miscompares++;
      $display("FAIL stall_end: got v=%b done=%b issues=%0d want 0 1 3", valid, done, issues);
    end
    working = 1'b0;
    step();
  endtask

  task automatic test_ignored_write();
    working = 1'b1;
    step();
    step();
    addr  = 5'd1;
    wdata = 32'hFFFFFFFF;
    wr    = 1'b1;
    step();
    wr = 1'b0;
    working = 1'b0;
    step();
    vectors++;
    if ({valid, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL write_abort: got valid=%b done=%b want 0 0", valid, done);
    end
    working = 1'b1;
    step();
    step();
    step();
    vectors++;
    if ({valid, ipc, icode, ifun, rA, rB, valC} !==
        {1'b1, 5'd1, 4'h1, 4'h0, 4'hF, 4'h1, 16'h0081}) begin
      miscompares++;
      $display("FAIL write_ignored: got v=%b ipc=%0d fields=%h %h %h %h %h want 1 1 1 0 f 1 0081",
               valid, ipc, icode, ifun, rA, rB, valC);
    end
    working = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) load_word(5'(i), 32'h20010000);
    working = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      step();
      vectors++;
      if ({valid, done, ipc, icode} !== {1'b1, 1'b0, 5'(i), 4'h2}) begin
        miscompares++;
        $display("FAIL full_issue%0d: got v=%b done=%b ipc=%0d icode=%h want 1 0 %0d 2",
                 i, valid, done, ipc, icode, i);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({valid, done, ipc} !== {1'b0, 1'b1, 5'd31}) begin
        miscompares++;
        $display("FAIL full_end%0d: got v=%b done=%b ipc=%0d want 0 1 31", i, valid, done, ipc);
      end
    end
    working = 1'b0;
    step();
  endtask

  task automatic test_drop_working();
    working = 1'b1;
    step();
    step();
    step();
    working = 1'b0;
    step();
    vectors++;
    if ({valid, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL drop_idle: got valid=%b done=%b want 0 0", valid, done);
    end
    working = 1'b1;
    step();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_reentry: valid=%b want 0", valid);
    end
    step();
    vectors++;
    if ({valid, ipc} !== {1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL drop_restart: got valid=%b ipc=%0d want 1 0", valid, ipc);
    end
  endtask

  task automatic test_async_reset();
    step();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({valid, done, ipc} !== {1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b done=%b ipc=%0d want 0 0 0", valid, done, ipc);
    end
    working = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step();
    working = 1'b1;
    step();
    step();
    vectors++;
    if ({valid, done} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_mem_cleared: got valid=%b done=%b want 0 1", valid, done);
    end
    working = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_stall();
    test_ignored_write();
    test_back_to_back();
    test_drop_working();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
